pipe_stage_elastic: RTL and testbench

- Parametrised successor to the fixed-field inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the RISC-V core.
- Carries a generic data payload and a control bundle between stages using a valid/ready handshake. Adds flush (bubble insert) and back-pressure stall, which the fixed-field registers lack.
- An optional skid buffer registers in_ready, cutting the combinational ready path through the stage.
- Control bits are forced to zero whenever the stage holds a bubble, so downstream never sees a spurious regesterW, memWrite or jump.

---
 rtl/pipe_stage_elastic.sv | 104 ++++++++++
 tb/tb_pipe_stage_elastic.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage pipeline register: valid/ready handshake, flush, and an
// optional skid register that makes in_ready a registered term.
module pipe_stage_elastic #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 12,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              main_valid, main_valid_n;
  logic [DATA_W-1:0] main_data, main_data_n;
  logic [CTRL_W-1:0] main_ctrl, main_ctrl_n;
  logic              skid_valid, skid_valid_n;
  logic [DATA_W-1:0] skid_data, skid_data_n;
  logic [CTRL_W-1:0] skid_ctrl, skid_ctrl_n;
  logic              in_xfer, out_xfer;

  // With a skid register, ready depends only on local state, never on out_ready.
  assign in_ready = !rst && !flush &&
                    ((SKID != 0) ? !skid_valid : (out_ready || !main_valid));

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;

  always_comb begin
    in_xfer      = in_valid && in_ready;
    out_xfer     = main_valid && out_ready;
    main_valid_n = main_valid;
    main_data_n  = main_data;
    main_ctrl_n  = main_ctrl;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;
    skid_ctrl_n  = skid_ctrl;
    if (flush) begin
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
    end else if (SKID == 0) begin
      if (in_xfer) begin
        main_valid_n = 1'b1;
        main_data_n  = in_data;
        main_ctrl_n  = in_ctrl;
      end else if (out_xfer) begin
        main_valid_n = 1'b0;
      end
    end else begin
      // A full skid always drains into main before any new input is taken.
      if (skid_valid) begin
        if (out_ready) begin
          main_data_n  = skid_data;
          main_ctrl_n  = skid_ctrl;
          skid_valid_n = 1'b0;
        end
      end else if (in_xfer) begin
        if (!main_valid || out_ready) begin
          main_valid_n = 1'b1;
          main_data_n  = in_data;
          main_ctrl_n  = in_ctrl;
        end else begin
          skid_valid_n = 1'b1;
          skid_data_n  = in_data;
          skid_ctrl_n  = in_ctrl;
        end
      end else if (out_xfer) begin
        main_valid_n = 1'b0;
      end
    end
    // Bubbles carry an all-zero control bundle from the register itself.
    if (!main_valid_n) main_ctrl_n = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_ctrl  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
      occupancy  <= '0;
    end else begin
      main_valid <= main_valid_n;
      main_data  <= main_data_n;
      main_ctrl  <= main_ctrl_n;
      skid_valid <= skid_valid_n;
      skid_data  <= skid_data_n;
      skid_ctrl  <= skid_ctrl_n;
      occupancy  <= {1'b0, main_valid_n} + {1'b0, skid_valid_n};
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Drives SKID=0 and SKID=1 instances with identical stimulus; each has its own
// queue-based reference model and output monitor.
module tb_pipe_stage_elastic;

  typedef struct packed {
    logic [31:0] d;
    logic [11:0] c;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic [11:0] in_ctrl;
  logic [1:0]  ir, ov;
  logic [31:0] od [2];
  logic [11:0] oc [2];
  logic [1:0]  occ [2];
  bit          started = 1'b0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.DATA_W(32), .CTRL_W(12), .SKID(0)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od[0]), .out_ctrl(oc[0]), .occupancy(occ[0]));

  pipe_stage_elastic #(.DATA_W(32), .CTRL_W(12), .SKID(1)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od[1]), .out_ctrl(oc[1]), .occupancy(occ[1]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : sb
    ent_t        q[$];
    logic [31:0] last_d = '0;
    logic        acc_ok = 1'b0;

    // Monitor: compares presented outputs against the model queue, pops on transfer.
    always @(negedge clk) begin
      logic er;
      if (started) begin
        er = !rst && !flush &&
             ((g == 0) ? (out_ready || q.size() == 0) : (q.size() < 2));
        acc_ok = er;
        chk($sformatf("u%0d_in_ready", g), ir[g], er);
        chk($sformatf("u%0d_out_valid", g), ov[g], q.size() != 0);
        chk($sformatf("u%0d_out_ctrl", g), oc[g], (q.size() != 0) ? q[0].c : 12'h0);
        chk($sformatf("u%0d_out_data", g), od[g], (q.size() != 0) ? q[0].d : last_d);
        chk($sformatf("u%0d_occupancy", g), occ[g], q.size());
        if (!rst && ov[g] && out_ready) begin
          chk($sformatf("u%0d_xfer_expected", g), 64'(q.size() != 0), 64'd1);
          if (q.size() != 0) begin
            chk($sformatf("u%0d_xfer_data", g), {oc[g], od[g]}, {q[0].c, q[0].d});
            void'(q.pop_front());
          end
        end
      end
    end

    // Model: records accepted entries, discards on reset or flush.
    always @(posedge clk) begin
      if (rst) begin
        q.delete();
        last_d = '0;
      end else if (flush) begin
        q.delete();
      end else if (in_valid && acc_ok) begin
        q.push_back({in_data, in_ctrl});
      end
      if (q.size() != 0) last_d = q[0].d;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic put(input logic [31:0] d, input logic [11:0] c);
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = c;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    nxt();
    started = 1'b1;
    nxt();
    rst = 1'b0;

    // Reset then stream at full rate.
    out_ready = 1'b1;
    put(32'h100, 12'h001); smp(); nxt();
    put(32'h104, 12'h001); smp();
    chk("stream_d0", od[1], 32'h100); chk("stream_occ0", occ[1], 1); nxt();
    put(32'h108, 12'h001); smp();
    chk("stream_d1", od[1], 32'h104); chk("stream_occ1", occ[1], 1); nxt();
    in_valid = 1'b0; smp();
    chk("stream_d2", od[1], 32'h108); chk("stream_occ2", occ[1], 1); nxt();
    smp(); chk("stream_drain", occ[1], 0); nxt();

    // Back-pressure into skid, then drain.
    out_ready = 1'b0;
    put(32'hA, 12'h00A); nxt();
    put(32'hB, 12'h00B); nxt();
    in_valid = 1'b0; smp();
    chk("bp_occ2", occ[1], 2); chk("bp_ready0", ir[1], 0); chk("bp_hold", od[1], 32'hA);
    nxt();
    out_ready = 1'b1; smp();
    chk("bp_out_a", od[1], 32'hA); chk("bp_occ_a", occ[1], 2); nxt();
    smp(); chk("bp_out_b", od[1], 32'hB); chk("bp_occ_b", occ[1], 1); nxt();
    smp(); chk("bp_occ_0", occ[1], 0); nxt();

    // Flush with the skid full.
    out_ready = 1'b0;
    put(32'h11, 12'h005); nxt();
    put(32'h22, 12'h006); nxt();
    put(32'h33, 12'hFFF); flush = 1'b1; smp();
    chk("flush_ready1", ir[1], 0); chk("flush_ready0", ir[0], 0); nxt();
    flush = 1'b0; in_valid = 1'b0; smp();
    chk("flush_valid", ov[1], 0); chk("flush_ctrl", oc[1], 12'h000);
    chk("flush_occ", occ[1], 0); chk("flush_data_kept", od[1], 32'h11);
    nxt();

    // Combinational ready on SKID=0 with toggling out_ready.
    for (int i = 0; i < 16; i++) begin
      put($urandom, 12'($urandom));
      out_ready = (i % 2) == 0;
      smp();
      if (ov[0]) chk("skid0_ready_mirror", ir[0], out_ready);
      nxt();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) nxt();

    // Reset mid-operation with the skid full.
    out_ready = 1'b0;
    put(32'h55, 12'h0AA); nxt();
    put(32'h66, 12'h0BB); nxt();
    in_valid = 1'b0; smp();
    chk("pre_rst_occ", occ[1], 2); nxt();
    rst = 1'b1; smp();
    chk("rst_ready", ir[1], 0); nxt();
    rst = 1'b0; smp();
    chk("rst_valid", ov[1], 0); chk("rst_data", od[1], 0);
    chk("rst_ctrl", oc[1], 0); chk("rst_occ", occ[1], 0); chk("rst_ready_after", ir[1], 1);
    nxt();

    // Random soak.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      in_data   = $urandom;
      in_ctrl   = 12'($urandom);
      out_ready = $urandom_range(0, 2) != 0;
      flush     = $urandom_range(0, 99) < 5;
      nxt();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
